neuron_operand_loader: RTL and testbench
========================================

// Module: neuron_operand_loader
// PURPOSE
//  Streaming front/back end for the parallel neuron (N-wide MAC chain + ReLU, registered output).
//  Accepts (weight, x) pairs one per beat over a valid/ready stream and assembles the N-wide operand vectors plus bias.
//  Holds the vectors stable while the neuron evaluates, then captures neuron_result and returns it on a valid/ready output stream.
//  Sits between the DMA/host stream and the neuron instance.
// PARAMETERS
//  N          64  vector length / number of beats per neuron evaluation (N >= 2)
//  precision  16  signed operand and result width
//  NEURON_LAT 1   neuron clock edges from stable operands to registered result (>= 1)
// PORTS
//  clk           in   1          rising-edge clock
//  rst           in   1          asynchronous, active-high reset
//  clear         in   1          sync abort: discard partial load or pending result
//  in_valid      in   1          beat valid
//  in_ready      out  1          loader accepts a beat this cycle
//  in_weight     in   precision  signed weight for element idx
//  in_x          in   precision  signed activation for element idx
//  in_bias       in   precision  signed bias; sampled on beat 0 only
//  weights       out  precision x N  operand vector to neuron
//  x             out  precision x N  operand vector to neuron
//  bias          out  precision  bias to neuron
//  neuron_result in   precision  neuron registered output
//  out_valid     out  1          out_result valid
//  out_ready     in   1          consumer accepts out_result
//  out_result    out  precision  captured neuron result
// BEHAVIOUR
//  Reset (async, rst=1): state=LOAD, idx=0, wait_cnt=0, out_valid=0, out_result=0, weights/x/bias all 0. in_ready=0 while rst=1.
//  in_ready = (state==LOAD) && !rst && !clear (combinational from registered state).
//  Beat accepted on an edge where in_valid && in_ready. Write weights[idx]<=in_weight and x[idx]<=in_x.
//    On idx==0, also bias<=in_bias.
//  idx counter is $clog2(N) bits and counts 0..N-1.
//    Accept at idx<N-1 increments idx.
//    Accept at idx==N-1: idx<=0, wait_cnt<=0, state->WAIT.
//  in_valid=0 in LOAD: no change, so gaps between beats are allowed.
//  WAIT:
//    - in_ready=0; weights/x/bias held constant.
//    - wait_cnt increments each edge.
//    - On the edge where wait_cnt==NEURON_LAT: out_result<=neuron_result, out_valid<=1, state->OUT.
//    - Result: out_valid rises NEURON_LAT+1 edges after the last-beat edge.
//  OUT:
//    - out_valid=1; out_result and the vectors held stable until the edge with out_ready=1.
//    - That edge sets out_valid<=0 and state->LOAD; in_ready is high in the following cycle.
//    - No bypass: a new beat cannot be accepted in the same cycle as the output handshake.
//  Vectors are not cleared between evaluations. Elements are overwritten beat by beat.
//  clear=1 on any edge (priority over all else): state->LOAD, idx<=0, wait_cnt<=0, out_valid<=0.
//    Vectors, bias and out_result are retained. A pending result is discarded.
//  Simultaneous clear and in_valid: no beat accepted (in_ready=0).
//  rst asserted mid-load or mid-WAIT/OUT: immediate return to reset values. No partial result is emitted.
//  No arithmetic in this block. All data is passed bit-exact (signed, precision bits).
//  Throughput: one evaluation per N + NEURON_LAT + 2 cycles minimum (N loads, WAIT, OUT handshake).
// TESTING
//  1) N=4, bias=2, w=x={1,2,3,4}, in_valid continuous -> in_ready drops after beat 3.
//     With a real neuron (NEURON_LAT=1), out_valid at edge+2 and out_result=32.
//  2) Same stream with negative bias -20 and w={1,1,1,1}, x={-1,-2,-3,-4} -> out_result=0 (ReLU).
//     Bias taken from beat 0 only; in_bias changed on beats 1-3 has no effect.
//  3) in_valid toggled every other cycle -> exactly 4 beats stored in order; result identical to test 1.
//  4) out_ready=0 for 10 cycles after out_valid -> out_valid and out_result stable, in_ready=0.
//     out_ready=1 -> out_valid=0 next cycle, in_ready=1.
//  5) clear after beat 2 of 4 -> idx=0, no out_valid.
//     Next full 4-beat load yields the correct result. clear while in OUT -> result dropped, in_ready=1.
//  6) rst pulse (mid-cycle, asynchronous) during WAIT -> out_valid=0 and vectors=0 immediately.
//     No output is produced afterwards until a fresh N-beat load.

Source files
------------

// File: rtl/neuron_operand_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_operand_loader_if
//  Description : Stream bundle for the neuron operand loader. It groups the
//                inbound (weight, x, bias) beat stream and the outbound
//                result stream.
//                  master : host / DMA side (drives beats, consumes results)
//                  slave  : loader side (accepts beats, presents results)
//  Signals     : in_valid/in_ready/in_weight/in_x/in_bias   beat stream
//                out_valid/out_ready/out_result             result stream
//  Revision    : 1.0  initial release
// ============================================================================
interface neuron_operand_loader_if #(
    parameter int PRECISION = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [PRECISION-1:0] in_weight;
    logic [PRECISION-1:0] in_x;
    logic [PRECISION-1:0] in_bias;
    logic                 out_valid;
    logic                 out_ready;
    logic [PRECISION-1:0] out_result;

    modport master (
        output in_valid, in_weight, in_x, in_bias, out_ready,
        input  in_ready, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_weight, in_x, in_bias, out_ready,
        output in_ready, out_valid, out_result
    );
endinterface
`default_nettype wire

// File: rtl/neuron_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_operand_loader
//  Description : Streaming front/back end for the parallel neuron. It collects
//                N (weight, x) beats into operand vectors (bias from beat 0),
//                holds them stable while the neuron evaluates, captures the
//                neuron's registered result and hands it out on a valid/ready
//                stream. No arithmetic; all data passes bit-exact.
//  Ports       : clk            rising-edge clock
//                rst            asynchronous active-high reset
//                clear          synchronous abort of partial load / result
//                bus (slave)    beat input stream and result output stream
//                weights, x     N x PRECISION operand vectors to the neuron
//                bias           bias to the neuron
//                neuron_result  neuron registered output
//  Revision    : 1.0  initial release
// ============================================================================
module neuron_operand_loader #(
    parameter int N          = 64,
    parameter int PRECISION  = 16,
    parameter int NEURON_LAT = 1
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic                           clear,
    neuron_operand_loader_if.slave              bus,
    output logic [N-1:0][PRECISION-1:0]         weights,
    output logic [N-1:0][PRECISION-1:0]         x,
    output logic [PRECISION-1:0]                bias,
    input  wire logic [PRECISION-1:0]           neuron_result
);

    localparam int IDX_W  = $clog2(N);
    localparam int WAIT_W = $clog2(NEURON_LAT + 1);

    localparam logic [IDX_W-1:0]  c_IDX_LAST  = IDX_W'(N - 1);
    localparam logic [WAIT_W-1:0] c_WAIT_LAST = WAIT_W'(NEURON_LAT);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                       r_state;
    logic [IDX_W-1:0]             r_idx;
    logic [WAIT_W-1:0]            r_wait_cnt;
    logic                         r_out_valid;
    logic [PRECISION-1:0]         r_out_result;
    logic [N-1:0][PRECISION-1:0]  r_weights;
    logic [N-1:0][PRECISION-1:0]  r_x;
    logic [PRECISION-1:0]         r_bias;

    logic                         w_in_ready;
    logic                         w_accept;

    // rst and clear gate ready directly so that no beat is ever reported as
    // accepted on an edge that the state register will ignore.
    assign w_in_ready = (r_state == ST_LOAD) && !rst && !clear;
    assign w_accept   = bus.in_valid && w_in_ready;

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign weights        = r_weights;
    assign x              = r_x;
    assign bias           = r_bias;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_LOAD;
            r_idx        <= '0;
            r_wait_cnt   <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_weights    <= '0;
            r_x          <= '0;
            r_bias       <= '0;
        end else if (clear) begin
            // Abort only the control path; operand vectors, bias and the last
            // captured result are kept.
            r_state     <= ST_LOAD;
            r_idx       <= '0;
            r_wait_cnt  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_weights[r_idx] <= bus.in_weight;
                        r_x[r_idx]       <= bus.in_x;
                        if (r_idx == '0) begin
                            r_bias <= bus.in_bias;
                        end
                        if (r_idx == c_IDX_LAST) begin
                            r_idx      <= '0;
                            r_wait_cnt <= '0;
                            r_state    <= ST_WAIT;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    // Operands became stable on the last-beat edge; the neuron
                    // result is valid after NEURON_LAT further edges, so it is
                    // sampled on the edge where the counter reaches that value.
                    r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        r_out_result <= neuron_result;
                        r_out_valid  <= 1'b1;
                        r_state      <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_neuron_operand_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_operand_loader
//  Description : Testbench for neuron_operand_loader (N=4, 16-bit,
//                NEURON_LAT=1) with a behavioural MAC+ReLU neuron, a result
//                scoreboard and directed load/handshake/clear/reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_neuron_operand_loader;

    localparam int N   = 4;
    localparam int P   = 16;
    localparam int LAT = 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                clear;
    logic [N-1:0][P-1:0] weights;
    logic [N-1:0][P-1:0] x;
    logic [P-1:0]        bias;
    logic [P-1:0]        neuron_result = '0;

    int checks = 0;
    int errors = 0;
    logic [P-1:0] sb[$];

    neuron_operand_loader_if #(.PRECISION(P)) bus ();

    neuron_operand_loader #(
        .N          (N),
        .PRECISION  (P),
        .NEURON_LAT (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .bus           (bus),
        .weights       (weights),
        .x             (x),
        .bias          (bias),
        .neuron_result (neuron_result)
    );

    always #5 clk = ~clk;

    // Behavioural neuron: one registered stage of bias + sum(w*x) then ReLU.
    function automatic logic [P-1:0] neuron_fn(input logic [N-1:0][P-1:0] w,
                                               input logic [N-1:0][P-1:0] xv,
                                               input logic [P-1:0] b);
        int acc;
        acc = int'($signed(b));
        for (int i = 0; i < N; i++) begin
            acc += int'($signed(w[i])) * int'($signed(xv[i]));
        end
        return (acc < 0) ? '0 : P'(acc);
    endfunction

    always @(posedge clk) neuron_result <= neuron_fn(weights, x, bias);

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares on every output handshake.
    initial begin
        logic [P-1:0] exp_v;
        forever begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    exp_v = sb.pop_front();
                    check("out_result", longint'($signed(bus.out_result)),
                          longint'($signed(exp_v)));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input int w, input int xv, input int b);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_weight = P'(w);
        bus.in_x      = P'(xv);
        bus.in_bias   = P'(b);
        while (!ok && n < 20) begin
            @(negedge clk);
            if (bus.in_ready) ok = 1'b1;
            else n++;
        end
        check("beat_accept", longint'(ok), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic load_vec(input int w[4], input int xv[4], input int b[4],
                            input bit gap, input int exp_res);
        sb.push_back(P'(exp_res));
        for (int i = 0; i < N; i++) begin
            if (gap && i > 0) begin
                @(posedge clk);
                #1;
            end
            send_beat(w[i], xv[i], b[i]);
        end
    endtask

    task automatic wait_out_valid();
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 20) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1'b1;
            else n++;
        end
        check("out_valid_wait", longint'(ok), 1);
    endtask

    initial begin
        rst           = 1'b1;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_weight = '0;
        bus.in_x      = '0;
        bus.in_bias   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_in_ready", longint'(bus.in_ready), 0);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_result", longint'(bus.out_result), 0);
        check("rst_vectors_zero", longint'(weights == '0 && x == '0 && bias == '0), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // 1) continuous stream, bias 2 -> 32, latency two edges after last beat
        load_vec('{1, 2, 3, 4}, '{1, 2, 3, 4}, '{2, 2, 2, 2}, 1'b0, 32);
        @(negedge clk);
        check("t1_in_ready_drop", longint'(bus.in_ready), 0);
        check("t1_out_valid_e0", longint'(bus.out_valid), 0);
        @(negedge clk);
        check("t1_out_valid_e1", longint'(bus.out_valid), 0);
        @(negedge clk);
        check("t1_out_valid_e2", longint'(bus.out_valid), 1);
        @(negedge clk);
        check("t1_out_valid_low", longint'(bus.out_valid), 0);
        check("t1_in_ready_back", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // 2) negative sum -> ReLU 0; bias only from beat 0
        load_vec('{1, 1, 1, 1}, '{-1, -2, -3, -4}, '{-20, 100, 200, 300}, 1'b0, 0);
        wait_out_valid();
        check("t2_bias_beat0", longint'($signed(bias)), -20);
        @(posedge clk);
        #1;

        // 3) in_valid every other cycle -> same result as test 1
        load_vec('{1, 2, 3, 4}, '{1, 2, 3, 4}, '{2, 2, 2, 2}, 1'b1, 32);
        wait_out_valid();
        check("t3_x3", longint'($signed(x[3])), 4);
        @(posedge clk);
        #1;

        // 4) consumer back-pressure for 10 cycles: 8-6-5+7+10 = 14
        bus.out_ready = 1'b0;
        load_vec('{2, -3, 5, 1}, '{4, 2, -1, 7}, '{10, 0, 0, 0}, 1'b0, 14);
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_hold_valid", longint'(bus.out_valid), 1);
            check("t4_hold_result", longint'($signed(bus.out_result)), 14);
            check("t4_hold_in_ready", longint'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_valid_drop", longint'(bus.out_valid), 0);
        check("t4_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // 5a) clear after 2 beats; simultaneous clear+in_valid is not accepted
        send_beat(7, 7, 7);
        send_beat(7, 7, 7);
        clear         = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_weight = P'(9);
        bus.in_x      = P'(9);
        @(negedge clk);
        check("t5_clear_in_ready", longint'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t5_no_out_valid", longint'(bus.out_valid), 0);
        end
        check("t5_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        // Fresh load starts at idx 0: 1+4+9+16+5 = 35
        load_vec('{1, 2, 3, 4}, '{1, 2, 3, 4}, '{5, 9, 9, 9}, 1'b0, 35);
        wait_out_valid();
        @(posedge clk);
        #1;

        // 5b) clear while result pending in OUT: 4+6+6+4 = 20, dropped
        bus.out_ready = 1'b0;
        load_vec('{1, 2, 3, 4}, '{4, 3, 2, 1}, '{0, 0, 0, 0}, 1'b0, 20);
        wait_out_valid();
        check("t5_pending_result", longint'($signed(bus.out_result)), 20);
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("t5_out_clear_valid", longint'(bus.out_valid), 0);
        check("t5_out_clear_ready", longint'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;

        // 6) asynchronous reset mid-WAIT
        load_vec('{3, 3, 3, 3}, '{1, 1, 1, 1}, '{0, 0, 0, 0}, 1'b0, 12);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_out_valid", longint'(bus.out_valid), 0);
        check("t6_rst_vectors", longint'(weights == '0 && x == '0 && bias == '0), 1);
        check("t6_rst_in_ready", longint'(bus.in_ready), 0);
        void'(sb.pop_back());
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t6_no_output", longint'(bus.out_valid), 0);
        end
        @(posedge clk);
        #1;
        load_vec('{1, 2, 3, 4}, '{1, 2, 3, 4}, '{2, 2, 2, 2}, 1'b0, 32);
        wait_out_valid();

        repeat (3) @(negedge clk);
        check("sb_empty", longint'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
